// File: rtl/counter_date_if.sv
// counter_date_if: set-path inputs and calendar outputs of the date counter.
`default_nettype none

interface counter_date_if;
  logic       en;
  logic       set_load;
  logic [4:0] set_numb_day;
  logic [3:0] set_numb_month;
  logic [6:0] set_numb_year;
  logic [2:0] set_numb_weekday;
  logic [4:0] day_w;
  logic [3:0] month_w;
  logic [6:0] year_w;
  logic [2:0] weekday_w;
  logic       leap_w;
  logic       month_clk;
  logic       year_clk;

  modport master (
    output en, set_load, set_numb_day, set_numb_month, set_numb_year, set_numb_weekday,
    input  day_w, month_w, year_w, weekday_w, leap_w, month_clk, year_clk
  );

  modport slave (
    input  en, set_load, set_numb_day, set_numb_month, set_numb_year, set_numb_weekday,
    output day_w, month_w, year_w, weekday_w, leap_w, month_clk, year_clk
  );
endinterface

`default_nettype wire

// File: rtl/counter_date.sv
// counter_date: day/month/year/weekday calendar clocked by the daily carry, rev 1.0
`default_nettype none

module counter_date #(
  parameter int YEAR_BASE     = 2000,
  parameter int START_WEEKDAY = 6
) (
  input  logic           day_clk,
  input  logic           rst,
  counter_date_if.slave  bus
);

  // Offsetting by the base keeps leap years aligned to the calendar if the base moves.
  localparam logic [1:0] C_BASE_MOD4 = 2'(YEAR_BASE % 4);
  localparam logic [2:0] C_START_WK  = 3'(START_WEEKDAY);

  function automatic logic is_leap(input logic [6:0] y);
    return (y[1:0] + C_BASE_MOD4) == 2'd0;
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return leap ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  logic [4:0] r_day;
  logic [3:0] r_month;
  logic [6:0] r_year;
  logic [2:0] r_wk;
  logic       r_mclk;
  logic       r_yclk;

  logic [4:0] w_day;
  logic [3:0] w_month;
  logic [6:0] w_year;
  logic [2:0] w_wk;
  logic       w_mclk;
  logic       w_yclk;

  logic [3:0] w_ld_month;
  logic [6:0] w_ld_year;
  logic [4:0] w_ld_last;
  logic [4:0] w_last;

  always_comb begin
    w_ld_month = ((bus.set_numb_month == 4'd0) || (bus.set_numb_month > 4'd12))
                 ? 4'd1 : bus.set_numb_month;
    w_ld_year  = (bus.set_numb_year > 7'd99) ? 7'd99 : bus.set_numb_year;
    w_ld_last  = days_in_month(w_ld_month, is_leap(w_ld_year));
    w_last     = days_in_month(r_month, is_leap(r_year));

    w_day   = r_day;
    w_month = r_month;
    w_year  = r_year;
    w_wk    = r_wk;
    w_mclk  = 1'b0;
    w_yclk  = 1'b0;

    if (bus.set_load) begin
      w_month = w_ld_month;
      w_year  = w_ld_year;
      if (bus.set_numb_day == 5'd0)
        w_day = 5'd1;
      else if (bus.set_numb_day > w_ld_last)
        w_day = w_ld_last;
      else
        w_day = bus.set_numb_day;
      w_wk = (bus.set_numb_weekday == 3'd7) ? 3'd0 : bus.set_numb_weekday;
    end else if (bus.en) begin
      w_wk = (r_wk == 3'd6) ? 3'd0 : r_wk + 3'd1;
      if (r_day < w_last) begin
        w_day = r_day + 5'd1;
      end else begin
        w_day  = 5'd1;
        w_mclk = 1'b1;
        if (r_month < 4'd12) begin
          w_month = r_month + 4'd1;
        end else begin
          w_month = 4'd1;
          w_yclk  = 1'b1;
          w_year  = (r_year == 7'd99) ? 7'd0 : r_year + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge day_clk or posedge rst) begin
    if (rst) begin
      r_day   <= 5'd1;
      r_month <= 4'd1;
      r_year  <= 7'd0;
      r_wk    <= C_START_WK;
      r_mclk  <= 1'b0;
      r_yclk  <= 1'b0;
    end else begin
      r_day   <= w_day;
      r_month <= w_month;
      r_year  <= w_year;
      r_wk    <= w_wk;
      r_mclk  <= w_mclk;
      r_yclk  <= w_yclk;
    end
  end

  assign bus.day_w     = r_day;
  assign bus.month_w   = r_month;
  assign bus.year_w    = r_year;
  assign bus.weekday_w = r_wk;
  assign bus.month_clk = r_mclk;
  assign bus.year_clk  = r_yclk;
  assign bus.leap_w    = is_leap(r_year);

endmodule

`default_nettype wire

// File: doc/counter_date.md
Name: counter_date

Overview:
- Calendar stage directly downstream of the hour counter.
- Consumes the hour counter's day_clk carry (one rising edge per day rollover) as its clock.
- Maintains day-of-month, month, year and weekday for the display/set logic.
- Handles month lengths and leap years, and supports a validated synchronous load from the set path.
- Emits month and year carry pulses for downstream consumers.

Parameters:
- YEAR_BASE, 2000: calendar year represented by year_w = 0. The leap rule below is valid for bases divisible by 400.
- START_WEEKDAY, 6: weekday_w value after reset (0 = Sunday, ..., 6 = Saturday). 6 matches 2000-01-01.

Ports:
- day_clk, input, 1: sole clock. Rising edge = one day elapsed.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: advance enable. Sampled on day_clk.
- set_load, input, 1: synchronous load of the set_* values. Sampled on day_clk.
- set_numb_day, input, 5: day to load (1..31).
- set_numb_month, input, 4: month to load (1..12).
- set_numb_year, input, 7: year offset to load (0..99).
- set_numb_weekday, input, 3: weekday to load (0..6).
- day_w, output, 5: current day of month, 1..31.
- month_w, output, 4: current month, 1..12.
- year_w, output, 7: year offset from YEAR_BASE, 0..99.
- weekday_w, output, 3: current weekday, 0..6.
- leap_w, output, 1: combinational, 1 when year_w[1:0] == 0.
- month_clk, output, 1: registered month-rollover pulse.
- year_clk, output, 1: registered year-rollover pulse.

Behaviour:
- Interface (already decided): one clock, day_clk. Reset rst is asynchronous and active-high.
- Reset state, applied immediately on rst high: day_w=1, month_w=1, year_w=0, weekday_w=START_WEEKDAY, month_clk=0, year_clk=0. State is held while rst is high.
- All outputs except leap_w are registered and update on the day_clk rising edge. Latency is one edge.
- Per-edge priority: rst > set_load > en > hold.
- days_in_month(m, y):
  - 31 for m = 1, 3, 5, 7, 8, 10, 12.
  - 30 for m = 4, 6, 9, 11.
  - February: 29 if y[1:0] == 0, else 28.
- Load (set_load=1), sanitised before storing; en is ignored:
  - month: 0 or >12 → 1.
  - year: >99 → 99.
  - day: 0 → 1; greater than days_in_month(sanitised month, sanitised year) → clamped to that last day.
  - weekday: 7 → 0.
  - month_clk=0, year_clk=0.
- Advance (set_load=0, en=1):
  - weekday_w wraps 6 → 0, otherwise increments.
  - day_w < days_in_month(month_w, year_w): day_w+1. Pulses 0.
  - day_w == last day and month_w < 12: day_w=1, month_w+1, month_clk=1, year_clk=0.
  - day_w == last day and month_w == 12: day_w=1, month_w=1, month_clk=1, year_clk=1. year_w wraps 99 → 0, otherwise increments.
- Hold (set_load=0, en=0): all counters unchanged. month_clk and year_clk forced to 0.
- Pulse timing: month_clk and year_clk are high for exactly one day_clk period, aligned with the edge that presents the rolled-over value. They are never high on two consecutive edges, because a month has at least 28 days.
- Illegal counter states are unreachable: load sanitises all values and advance only produces legal ones. No recovery logic is required.
- rst asserted mid-run, including coincident with set_load or a rollover edge: reset values win. The first edge after release operates from the reset state.
- No combinational path from set_* inputs to any output. leap_w depends on year_w only.

Test Plan:
- Reset: assert rst with no clock edge → day_w=1, month_w=1, year_w=0, weekday_w=6, month_clk=0, year_clk=0 immediately. Release, then 1 edge with en=1 → day_w=2, weekday_w=0.
- Month rollover: load 31/01/year 5, then 1 edge en=1 → day_w=1, month_w=2, month_clk=1 for one edge, year_clk=0. Next edge → month_clk=0.
- Leap vs non-leap: load 28/02/year 24, then 2 edges → 29/02, then 01/03 with month_clk=1. Load 28/02/year 23, then 1 edge → 01/03.
- Year and century wrap: load 31/12/year 99, then 1 edge → 01/01/year 0, month_clk=1, year_clk=1, leap_w=1.
- Load sanitising:
  - set 30/02/year 23 → day_w=28.
  - set 31/04 → day_w=30.
  - set month 0, day 0, year 120, weekday 7 → 01/01/year 99, weekday_w=0.
- Enable and async reset: with en=0, 5 edges → all values unchanged, pulses 0. Pulse rst mid-run between edges → reset state immediately, with no edge required.
